alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 A  input  DATA_WIDTH  operand A.
REQ-005 B  input  DATA_WIDTH  operand B.
REQ-006 ALUop  input  3  operation select.
REQ-007 Result  output  DATA_WIDTH  registered operation result.
REQ-008 Overflow  output  1  registered two's-complement overflow flag.
REQ-009 CarryOut  output  1  registered carry/borrow flag.
REQ-010 Zero  output  1  registered flag, 1 when Result is all zeros.

Function
REQ-011 Opcodes SHALL be: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
REQ-012 Latency SHALL be 1 cycle: outputs SHALL reflect the A, B and ALUop sampled at the previous rising edge; there SHALL be no handshake; a new operation SHALL be accepted every cycle.
REQ-013 AND: Result = A & B, with Overflow=0 and CarryOut=0.
REQ-014 OR: Result = A | B, with Overflow=0 and CarryOut=0.
REQ-015 ADD: Result = (A + B) mod 2^DATA_WIDTH.
REQ-016 ADD: CarryOut SHALL be the carry out of the MSB.
REQ-017 ADD: Overflow SHALL be 1 when A and B have the same sign and Result's sign differs.
REQ-018 SUB: Result = A + ~B + 1, mod 2^DATA_WIDTH.
REQ-019 SUB: CarryOut SHALL be 1 iff A < B unsigned (borrow).
REQ-020 SUB: Overflow SHALL be 1 when the signs of A and B differ and Result's sign differs from A's.
REQ-021 SLT: Result = 1 if A < B signed, else 0, with upper bits zero.
REQ-022 SLT: the comparison SHALL be computed as sign(A-B) XOR overflow(A-B), so it is correct at boundary values.
REQ-023 SLT: Overflow=0 and CarryOut=0.
REQ-024 Zero SHALL equal (Result == 0) for every opcode, including logical ops and SLT.
REQ-025 Undefined opcodes (011, 100, 101) SHALL produce Result=0, Overflow=0, CarryOut=0, Zero=1.
REQ-026 Wrap-around SHALL be silent: Result is always truncated to DATA_WIDTH bits; only the flags report overflow or carry.

Reset
REQ-027 When rst=1 at a rising edge, the next outputs SHALL be Result=0, Overflow=0, CarryOut=0, Zero=1.
REQ-028 Reset SHALL take priority over any operation in the same cycle.
REQ-029 The first cycle after rst deasserts SHALL register the operation presented in that cycle; no operation issued during reset SHALL survive.

Structure
REQ-030 A shared package SHALL hold the DATA_WIDTH default and the five opcode constants; the package SHALL be reused by the decoder and the testbench.
REQ-031 One sub-module, alu_adder, SHALL implement the DATA_WIDTH adder with carry-in and output sum, carry-out and overflow.
REQ-032 alu_adder SHALL be shared by ADD, SUB and SLT, with B inverted and carry-in=1 for SUB and SLT.
REQ-033 The opcode mux and output registers SHALL reside in alu.

Verification
REQ-034 Reset: rst=1 for 2 cycles -> Result=0, Zero=1, Overflow=0, CarryOut=0.
REQ-035 ADD: A=1, B=1 -> 2. A=88, B=5 -> 93.
REQ-036 ADD overflow: A=0x7FFFFFFF, B=1 -> 0x80000000, Overflow=1, CarryOut=0.
REQ-037 ADD carry: A=0xFFFFFFFF, B=1 -> Result=0, CarryOut=1, Zero=1, Overflow=0.
REQ-038 SUB: A=111, B=111 -> Result=0, Zero=1, CarryOut=0. A=1555, B=11111 -> 0xFFFFDAAC (-9556), CarryOut=1, Overflow=0.
REQ-039 Logical/SLT with A=1555, B=11111 -> AND gives 515; OR gives 12151; SLT gives 1. SLT with A=0x80000000, B=1 -> 1.
REQ-040 Undefined ALUop=011 -> Result=0, Zero=1.
REQ-041 Back-to-back ops on consecutive cycles -> each result appears exactly 1 cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and opcode encodings.
// Used by the RTL decoder and by the testbench model.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_adder.sv
// Ripple-free behavioural adder with carry-in, carry-out and signed overflow.
// Shared by ADD, SUB and SLT; the caller pre-inverts B for subtraction.
module alu_adder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_cin,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_cout,
    output logic                  o_ovf
);

    logic [DATA_WIDTH:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{DATA_WIDTH{1'b0}}, i_cin};
    assign o_sum  = w_full[DATA_WIDTH-1:0];
    assign o_cout = w_full[DATA_WIDTH];
    // Operands agree in sign but the sum does not: signed wrap.
    assign o_ovf  = (i_a[DATA_WIDTH-1] == i_b[DATA_WIDTH-1]) &&
                    (o_sum[DATA_WIDTH-1] != i_a[DATA_WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Single-cycle-latency ALU: opcode mux over a shared adder, with all
// outputs registered and a synchronous active-high reset.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Overflow,
    output logic                  CarryOut,
    output logic                  Zero
);

    logic                  w_sub;
    logic [DATA_WIDTH-1:0] w_b_in;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_cout;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_flag_v;
    logic                  w_flag_c;

    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_ovf;
    logic                  r_carry;
    logic                  r_zero;

    // SUB and SLT both compute A + ~B + 1.
    assign w_sub  = (ALUop == OP_SUB) || (ALUop == OP_SLT);
    assign w_b_in = w_sub ? ~B : B;

    alu_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .i_a    (A),
        .i_b    (w_b_in),
        .i_cin  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        w_result = '0;
        w_flag_v = 1'b0;
        w_flag_c = 1'b0;
        case (ALUop)
            OP_AND: w_result = A & B;
            OP_OR:  w_result = A | B;
            OP_ADD: begin
                w_result = w_sum;
                w_flag_v = w_ovf;
                w_flag_c = w_cout;
            end
            OP_SUB: begin
                w_result = w_sum;
                w_flag_v = w_ovf;
                // No carry out of A + ~B + 1 means a borrow occurred.
                w_flag_c = ~w_cout;
            end
            OP_SLT: w_result = {{(DATA_WIDTH-1){1'b0}}, w_sum[DATA_WIDTH-1] ^ w_ovf};
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= w_result;
            r_ovf    <= w_flag_v;
            r_carry  <= w_flag_c;
            r_zero   <= (w_result == '0);
        end
    end

    assign Result   = r_result;
    assign Overflow = r_ovf;
    assign CarryOut = r_carry;
    assign Zero     = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random ops checked
// against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUop;
    logic [31:0] Result;
    logic        Overflow;
    logic        CarryOut;
    logic        Zero;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] r;
        logic        v;
        logic        c;
        logic        z;
    } exp_t;

    alu #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALUop    (ALUop),
        .Result   (Result),
        .Overflow (Overflow),
        .CarryOut (CarryOut),
        .Zero     (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        exp_t   e;
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        e.r = 32'd0;
        e.v = 1'b0;
        e.c = 1'b0;
        case (op)
            OP_AND: e.r = a & b;
            OP_OR:  e.r = a | b;
            OP_ADD: begin
                e.r = a + b;
                e.c = (ua + ub) > 64'sd4294967295;
                s   = sa + sb;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                e.r = a - b;
                e.c = ua < ub;
                s   = sa - sb;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLT: e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one operation, then check the registered outputs one edge later.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic r, input string tag);
        exp_t e;
        @(negedge clk);
        A     = a;
        B     = b;
        ALUop = op;
        rst   = r;
        if (r) begin
            e.r = 32'd0; e.v = 1'b0; e.c = 1'b0; e.z = 1'b1;
        end else begin
            e = model(a, b, op);
        end
        @(posedge clk);
        #1;
        check({tag, ".Result"},   Result,           e.r);
        check({tag, ".Overflow"}, {31'd0, Overflow}, {31'd0, e.v});
        check({tag, ".CarryOut"}, {31'd0, CarryOut}, {31'd0, e.c});
        check({tag, ".Zero"},     {31'd0, Zero},     {31'd0, e.z});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        A     = 32'd0;
        B     = 32'd0;
        ALUop = 3'd0;

        // Reset for two cycles, with live operations that must be discarded.
        step(32'd5, 32'd7, OP_ADD, 1'b1, "reset0");
        step(32'hFFFFFFFF, 32'd1, OP_ADD, 1'b1, "reset1");

        // First cycle after reset registers its own operation.
        step(32'd1, 32'd1, OP_ADD, 1'b0, "add_1_1");
        check("add_1_1.direct", Result, 32'd2);
        step(32'd88, 32'd5, OP_ADD, 1'b0, "add_88_5");
        check("add_88_5.direct", Result, 32'd93);
        step(32'h7FFFFFFF, 32'd1, OP_ADD, 1'b0, "add_ovf");
        check("add_ovf.direct", {Result[31:0], Overflow, CarryOut}, {32'h80000000, 1'b1, 1'b0});
        step(32'hFFFFFFFF, 32'd1, OP_ADD, 1'b0, "add_carry");
        check("add_carry.direct", {Result, CarryOut, Zero, Overflow}, {32'd0, 1'b1, 1'b1, 1'b0});
        step(32'd111, 32'd111, OP_SUB, 1'b0, "sub_eq");
        check("sub_eq.direct", {Result, Zero, CarryOut}, {32'd0, 1'b1, 1'b0});
        step(32'd1555, 32'd11111, OP_SUB, 1'b0, "sub_neg");
        check("sub_neg.direct", {Result, CarryOut, Overflow}, {32'hFFFFDAAC, 1'b1, 1'b0});
        step(32'd1555, 32'd11111, OP_AND, 1'b0, "and");
        check("and.direct", Result, 32'd515);
        step(32'd1555, 32'd11111, OP_OR, 1'b0, "or");
        check("or.direct", Result, 32'd12151);
        step(32'd1555, 32'd11111, OP_SLT, 1'b0, "slt");
        check("slt.direct", Result, 32'd1);
        step(32'h80000000, 32'd1, OP_SLT, 1'b0, "slt_min");
        check("slt_min.direct", Result, 32'd1);
        step(32'h7FFFFFFF, 32'h80000000, OP_SLT, 1'b0, "slt_max_min");
        step(32'h80000000, 32'd1, OP_SUB, 1'b0, "sub_ovf");
        step(32'd9, 32'd3, 3'b011, 1'b0, "undef011");
        check("undef011.direct", {Result, Zero}, {32'd0, 1'b1});
        step(32'd9, 32'd3, 3'b100, 1'b0, "undef100");
        step(32'd9, 32'd3, 3'b101, 1'b0, "undef101");

        // Reset mid-stream takes priority, then operation resumes.
        step(32'd2, 32'd3, OP_ADD, 1'b1, "reset_mid");
        step(32'd2, 32'd3, OP_ADD, 1'b0, "after_reset");

        // Back-to-back random ops, biased toward boundary operands.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [2:0]  rop;
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'h7FFFFFFF;
                2: rb = ra;
                3: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            step(ra, rb, rop, 1'b0, $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
